id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 141 ++++++++++++++
 tb/tb_id_ex_reg.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use hazard detection and a
// saturating counter of inserted load-use bubbles.
module id_ex_reg #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [31:0]       id_rd1,
  input  logic [31:0]       id_rd2,
  input  logic [31:0]       id_imm32,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              hold,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_rd1,
  output logic [31:0]       ex_rd2,
  output logic [31:0]       ex_imm32,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Control bundle bit holding MemRead; a load in EX is what creates the hazard.
  localparam int MEMREAD_BIT = 1;

  logic              ex_valid_q, ex_valid_d;
  logic [31:0]       ex_pc_q,    ex_pc_d;
  logic [4:0]        ex_rs_q,    ex_rs_d;
  logic [4:0]        ex_rt_q,    ex_rt_d;
  logic [4:0]        ex_rd_q,    ex_rd_d;
  logic [31:0]       ex_rd1_q,   ex_rd1_d;
  logic [31:0]       ex_rd2_q,   ex_rd2_d;
  logic [31:0]       ex_imm32_q, ex_imm32_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

  logic hazard;
  logic rs_match;
  logic rt_match;

  // Detect a load in EX whose destination is read by the ID instruction.
  // $0 is never a real dependency, so a load targeting it cannot stall.
  assign rs_match = id_uses_rs & (id_rs == ex_rt_q);
  assign rt_match = id_uses_rt & (id_rt == ex_rt_q);
  assign hazard   = ex_valid_q & ex_ctrl_q[MEMREAD_BIT] & (ex_rt_q != 5'd0)
                  & id_valid & (rs_match | rt_match);

  // A flush or downstream hold already dominates the edge, so no bubble is needed.
  assign load_use_stall = hazard & ~hold & ~flush;

  // Next-state selection in priority order flush > hold > bubble > load.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_pc_d      = ex_pc_q;
    ex_rs_d      = ex_rs_q;
    ex_rt_d      = ex_rt_q;
    ex_rd_d      = ex_rd_q;
    ex_rd1_d     = ex_rd1_q;
    ex_rd2_d     = ex_rd2_q;
    ex_imm32_d   = ex_imm32_q;
    ex_ctrl_d    = ex_ctrl_q;
    bubble_cnt_d = bubble_cnt_q;

    if (flush) begin
      // Data fields are left as-is; only valid and control matter once killed.
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
    end else if (hold) begin
      // Everything stays frozen.
    end else if (load_use_stall) begin
      // Bubble: the ID instruction stays upstream and is captured next edge.
      ex_valid_d = 1'b0;
      ex_ctrl_d  = '0;
      if (bubble_cnt_q != {CNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      end
    end else begin
      ex_valid_d = id_valid;
      ex_pc_d    = id_pc;
      ex_rs_d    = id_rs;
      ex_rt_d    = id_rt;
      ex_rd_d    = id_rd;
      ex_rd1_d   = id_rd1;
      ex_rd2_d   = id_rd2;
      ex_imm32_d = id_imm32;
      // An empty slot never carries side-effecting control bits.
      ex_ctrl_d  = id_valid ? id_ctrl : '0;
    end
  end

  // State register; reset overrides any stall, hold or flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q   <= 1'b0;
      ex_pc_q      <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_rd_q      <= '0;
      ex_rd1_q     <= '0;
      ex_rd2_q     <= '0;
      ex_imm32_q   <= '0;
      ex_ctrl_q    <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_pc_q      <= ex_pc_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_rd_q      <= ex_rd_d;
      ex_rd1_q     <= ex_rd1_d;
      ex_rd2_q     <= ex_rd2_d;
      ex_imm32_q   <= ex_imm32_d;
      ex_ctrl_q    <= ex_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_pc      = ex_pc_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_rd      = ex_rd_q;
  assign ex_rd1     = ex_rd1_q;
  assign ex_rd2     = ex_rd2_q;
  assign ex_imm32   = ex_imm32_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: a driver applies directed vectors and
// queues their hand-computed expectations; a monitor pops and compares.
module tb_id_ex_reg;

  localparam int CTRL_W = 8;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              rst, flush, hold;
  logic              id_valid, id_uses_rs, id_uses_rt;
  logic [31:0]       id_pc, id_rd1, id_rd2, id_imm32;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_valid, load_use_stall;
  logic [31:0]       ex_pc, ex_rd1, ex_rd2, ex_imm32;
  logic [4:0]        ex_rs, ex_rt, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  bubble_cnt;

  always #5 clk = ~clk;

  id_ex_reg #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm32(id_imm32), .id_ctrl(id_ctrl),
    .flush(flush), .hold(hold),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm32(ex_imm32), .ex_ctrl(ex_ctrl),
    .load_use_stall(load_use_stall), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic        rst, flush, hold, v;
    logic [31:0] pc;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [7:0]  ctrl;
    logic [31:0] imm;
    logic        e_stall, e_valid;
    logic [7:0]  e_ctrl;
    logic [31:0] e_pc;
    logic [4:0]  e_rs, e_rt;
    logic [31:0] e_imm;
    int          e_cnt;
    logic        cd, cs;   // check data fields / check stall output
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done  = 0;
  int   txn   = 0;

  task automatic vec(input logic r, f, h, v, input logic [31:0] pc,
                     input logic [4:0] rs, rt, input logic urs, urt,
                     input logic [7:0] ctrl, input logic [31:0] imm,
                     input logic es, ev, input logic [7:0] ec,
                     input logic [31:0] epc, input logic [4:0] ers, ert,
                     input logic [31:0] eimm, input int ecnt,
                     input logic cd, cs);
    vec_t t;
    t.rst = r; t.flush = f; t.hold = h; t.v = v; t.pc = pc; t.rs = rs; t.rt = rt;
    t.urs = urs; t.urt = urt; t.ctrl = ctrl; t.imm = imm;
    t.e_stall = es; t.e_valid = ev; t.e_ctrl = ec; t.e_pc = epc; t.e_rs = ers;
    t.e_rt = ert; t.e_imm = eimm; t.e_cnt = ecnt; t.cd = cd; t.cs = cs;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL txn %0d %s: got %h expected %h", txn, name, act, exp_v);
    end
  endtask

  // Driver: apply one vector per cycle on the falling edge and queue its expectation.
  initial begin
    rst = 1'b1; flush = 0; hold = 0; id_valid = 0; id_pc = 0; id_rs = 0; id_rt = 0;
    id_rd = 0; id_uses_rs = 0; id_uses_rt = 0; id_rd1 = 0; id_rd2 = 0; id_imm32 = 0;
    id_ctrl = 0;
    //  rst f h v  pc          rs rt urs urt ctrl  imm            es ev ectrl epc         ers ert eimm          cnt cd cs
    vec(1, 0,0,1, 32'h100,    2, 8, 1, 0, 8'h03, 32'h4,          0, 0, 8'h00, 32'h0,     0, 0, 32'h0,          0, 1, 0); // reset
    vec(1, 0,0,1, 32'h100,    2, 8, 1, 0, 8'h03, 32'h4,          0, 0, 8'h00, 32'h0,     0, 0, 32'h0,          0, 1, 1); // reset held
    vec(0, 0,0,1, 32'h100,    2, 8, 1, 0, 8'h03, 32'h4,          0, 1, 8'h03, 32'h100,   2, 8, 32'h4,          0, 1, 1); // lw $8
    vec(0, 0,0,1, 32'h104,    8, 9, 1, 1, 8'h01, 32'h0,          1, 0, 8'h00, 32'h0,     0, 0, 32'h0,          1, 0, 1); // add rs=8 -> bubble
    vec(0, 0,0,1, 32'h104,    8, 9, 1, 1, 8'h01, 32'h0,          0, 1, 8'h01, 32'h104,   8, 9, 32'h0,          1, 1, 1); // add enters EX
    vec(0, 0,0,1, 32'h108,    3, 0, 1, 0, 8'h03, 32'h8,          0, 1, 8'h03, 32'h108,   3, 0, 32'h8,          1, 1, 1); // lw $0
    vec(0, 0,0,1, 32'h10c,    0, 0, 1, 1, 8'h01, 32'h0,          0, 1, 8'h01, 32'h10c,   0, 0, 32'h0,          1, 1, 1); // ex_rt=0: no stall
    vec(0, 0,0,1, 32'h110,    1, 8, 1, 0, 8'h03, 32'hc,          0, 1, 8'h03, 32'h110,   1, 8, 32'hc,          1, 1, 1); // lw $8
    vec(0, 0,0,1, 32'h114,    8, 5, 0, 1, 8'h01, 32'h0,          0, 1, 8'h01, 32'h114,   8, 5, 32'h0,          1, 1, 1); // rs=8 unused: no stall
    vec(0, 0,0,1, 32'h118,    1, 8, 1, 0, 8'h03, 32'h0,          0, 1, 8'h03, 32'h118,   1, 8, 32'h0,          1, 1, 1); // lw $8
    vec(0, 1,0,1, 32'h11c,    8, 9, 1, 0, 8'h01, 32'h0,          0, 0, 8'h00, 32'h0,     0, 0, 32'h0,          1, 0, 1); // flush beats stall
    vec(0, 0,0,1, 32'h120,    1, 8, 1, 0, 8'h03, 32'h10,         0, 1, 8'h03, 32'h120,   1, 8, 32'h10,         1, 1, 1); // lw $8
    vec(0, 0,1,1, 32'h124,    8, 9, 1, 0, 8'h01, 32'hffff8000,   0, 1, 8'h03, 32'h120,   1, 8, 32'h10,         1, 1, 1); // hold 1
    vec(0, 0,1,1, 32'h128,    8, 9, 1, 0, 8'h01, 32'h1234,       0, 1, 8'h03, 32'h120,   1, 8, 32'h10,         1, 1, 1); // hold 2
    vec(0, 0,1,1, 32'h124,    8, 9, 1, 0, 8'h01, 32'hffff8000,   0, 1, 8'h03, 32'h120,   1, 8, 32'h10,         1, 1, 1); // hold 3
    vec(0, 0,0,1, 32'h124,    8, 9, 0, 0, 8'h01, 32'hffff8000,   0, 1, 8'h01, 32'h124,   8, 9, 32'hffff8000,   1, 1, 1); // release
    vec(1, 0,0,0, 32'h0,      0, 0, 0, 0, 8'h00, 32'h0,          0, 0, 8'h00, 32'h0,     0, 0, 32'h0,          0, 1, 1); // reset
    vec(0, 0,0,1, 32'h300,    1, 8, 1, 0, 8'h03, 32'h0,          0, 1, 8'h03, 32'h300,   1, 8, 32'h0,          0, 1, 1); // lw $8
    vec(0, 0,0,1, 32'h304,    8, 8, 1, 0, 8'h03, 32'h0,          1, 0, 8'h00, 32'h0,     0, 0, 32'h0,          1, 0, 1); // pair 1
    vec(0, 0,0,1, 32'h304,    8, 8, 1, 0, 8'h03, 32'h0,          0, 1, 8'h03, 32'h304,   8, 8, 32'h0,          1, 1, 1);
    vec(0, 0,0,1, 32'h308,    8, 8, 1, 0, 8'h03, 32'h0,          1, 0, 8'h00, 32'h0,     0, 0, 32'h0,          2, 0, 1); // pair 2
    vec(0, 0,0,1, 32'h308,    8, 8, 1, 0, 8'h03, 32'h0,          0, 1, 8'h03, 32'h308,   8, 8, 32'h0,          2, 1, 1);
    vec(0, 0,0,1, 32'h30c,    8, 8, 1, 0, 8'h03, 32'h0,          1, 0, 8'h00, 32'h0,     0, 0, 32'h0,          3, 0, 1); // pair 3
    vec(0, 0,0,1, 32'h30c,    8, 8, 1, 0, 8'h03, 32'h0,          0, 1, 8'h03, 32'h30c,   8, 8, 32'h0,          3, 1, 1);
    vec(0, 0,0,1, 32'h310,    8, 8, 1, 0, 8'h03, 32'h0,          1, 0, 8'h00, 32'h0,     0, 0, 32'h0,          3, 0, 1); // pair 4 saturates
    vec(0, 0,0,1, 32'h310,    8, 8, 1, 0, 8'h03, 32'h0,          0, 1, 8'h03, 32'h310,   8, 8, 32'h0,          3, 1, 1);
    vec(1, 0,1,1, 32'h314,    8, 8, 1, 0, 8'h03, 32'h0,          0, 0, 8'h00, 32'h0,     0, 0, 32'h0,          0, 1, 1); // rst during hold
    vec(0, 0,0,1, 32'h200,    8, 9, 1, 1, 8'h01, 32'h7,          0, 1, 8'h01, 32'h200,   8, 9, 32'h7,          0, 1, 1); // resume load
    vec(0, 0,0,0, 32'h204,    1, 2, 1, 1, 8'h07, 32'h9,          0, 0, 8'h00, 32'h204,   1, 2, 32'h9,          0, 1, 1); // invalid: ctrl zeroed
    vec(0, 0,0,1, 32'h208,    1, 5, 1, 0, 8'h03, 32'h0,          0, 1, 8'h03, 32'h208,   1, 5, 32'h0,          0, 1, 1); // lw $5
    vec(0, 0,0,1, 32'h20c,    6, 5, 0, 1, 8'h04, 32'h0,          1, 0, 8'h00, 32'h0,     0, 0, 32'h0,          1, 0, 1); // sw rt=5 stalls
    vec(0, 0,0,1, 32'h20c,    6, 5, 0, 1, 8'h04, 32'h0,          0, 1, 8'h04, 32'h20c,   6, 5, 32'h0,          1, 1, 1);
    vec(0, 0,0,1, 32'h210,    1, 5, 1, 0, 8'h03, 32'h0,          0, 1, 8'h03, 32'h210,   1, 5, 32'h0,          1, 1, 1); // lw $5
    vec(0, 0,0,0, 32'h214,    5, 0, 1, 0, 8'h01, 32'h0,          0, 0, 8'h00, 32'h214,   5, 0, 32'h0,          1, 1, 1); // id invalid: no stall

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; flush = vecs[i].flush; hold = vecs[i].hold;
      id_valid = vecs[i].v; id_pc = vecs[i].pc; id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_rd = vecs[i].pc[6:2]; id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
      id_rd1 = vecs[i].pc + 32'h1000; id_rd2 = ~vecs[i].pc;
      id_imm32 = vecs[i].imm; id_ctrl = vecs[i].ctrl;
      exp_q.push_back(vecs[i]);
    end
    repeat (3) @(negedge clk);
    done = 1;
  end

  // Monitor: sample the combinational stall just before the edge and the
  // registered outputs just after it, then retire the oldest expectation.
  initial begin
    vec_t e;
    logic s;
    forever begin
      @(negedge clk);
      #4;
      s = load_use_stall;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.cs) check("load_use_stall", {31'd0, s}, {31'd0, e.e_stall});
        check("ex_valid", {31'd0, ex_valid}, {31'd0, e.e_valid});
        check("ex_ctrl", {24'd0, ex_ctrl}, {24'd0, e.e_ctrl});
        check("bubble_cnt", {30'd0, bubble_cnt}, e.e_cnt);
        if (e.cd) begin
          check("ex_pc", ex_pc, e.e_pc);
          check("ex_rs", {27'd0, ex_rs}, {27'd0, e.e_rs});
          check("ex_rt", {27'd0, ex_rt}, {27'd0, e.e_rt});
          check("ex_rd", {27'd0, ex_rd}, {27'd0, e.e_pc[6:2]});
          check("ex_imm32", ex_imm32, e.e_imm);
          check("ex_rd1", ex_rd1, e.rst ? 32'h0 : e.e_pc + 32'h1000);
          check("ex_rd2", ex_rd2, e.rst ? 32'h0 : ~e.e_pc);
        end
        $display("txn %0d: pc=%h stall=%0b ex_valid=%0b ex_ctrl=%h ex_pc=%h bubble_cnt=%0d",
                 txn, e.pc, s, ex_valid, ex_ctrl, ex_pc, bubble_cnt);
        txn++;
      end
    end
  end

  // Finish once the driver is done, or give up after a fixed time budget.
  initial begin
    fork
      wait (done);
      #20000;
    join_any
    disable fork;
    n_cmp++;
    if (!done || exp_q.size() != 0 || txn != vecs.size()) begin
      n_bad++;
      $display("FAIL completion: done=%0b pending=%0d retired=%0d expected %0d retired",
               done, exp_q.size(), txn, vecs.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
